// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream mux, explicit select or round-robin arbitration with packet locking.
module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          Sin,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e            lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d, ptr_q, ptr_d, out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_idx, scan_idx, g_idx;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             rr_found, g_vld, can_load, xfer;
  logic [WIDTH-1:0] ch_data [CHANNELS];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end
  // Scan from the farthest candidate back to ptr+1 so the nearest valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      scan_idx = SEL_W'((int'(ptr_q) + k) % CHANNELS);
      if (in_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end
  always_comb begin
    can_load    = !out_valid_q || out_ready;
    g_vld       = !mode ? ({1'b0, Sin} < (SEL_W+1)'(CHANNELS)) : (lock_q == LOCKED) || rr_found;
    g_idx       = !mode ? Sin : (lock_q == LOCKED) ? lock_ch_q : rr_idx;
    in_ready    = (reset_n && can_load && g_vld) ? CHANNELS'(1) << g_idx : '0;
    xfer        = |(in_valid & in_ready);
    out_valid_d = xfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d  = xfer ? ch_data[g_idx] : out_data_q;
    out_last_d  = xfer ? in_last[g_idx] : out_last_q;
    out_ch_d    = xfer ? g_idx : out_ch_q;
    ptr_d       = (xfer && mode) ? g_idx : ptr_q;
    lock_ch_d   = (xfer && mode) ? g_idx : lock_ch_q;
    lock_d      = !mode ? UNLOCKED : !xfer ? lock_q : in_last[g_idx] ? UNLOCKED : LOCKED;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
      lock_ch_q   <= '0;
      lock_q      <= UNLOCKED;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      lock_q      <= lock_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
endmodule
